// File: rtl/injection_scheduler.sv
// Bufferless-mesh router injection/ejection controller with local PE FIFO.
// Define INJ_STATS_EN to add saturating injection/ejection/stall counters.
module injection_scheduler #(
  parameter int ROW_ID = 4,
  parameter int COL_ID = 4,
  parameter int DEPTH  = 4,
  parameter int PW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [23:0]     in_addr,
  input  logic [4*PW-1:0] in_data,
  input  logic            loc_valid,
  input  logic [5:0]      loc_addr,
  input  logic [PW-1:0]   loc_data,
  output logic            loc_ready,
  output logic [3:0]      out_valid,
  output logic [23:0]     out_addr,
  output logic [4*PW-1:0] out_data,
  output logic [19:0]     out_dir,
  output logic            ej_valid,
  output logic [5:0]      ej_addr,
  output logic [PW-1:0]   ej_data
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]     stat_inj,
  output logic [15:0]     stat_ej,
  output logic [15:0]     stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 6 + PW;
  localparam logic [2:0] ROW = 3'(ROW_ID);
  localparam logic [2:0] COL = 3'(COL_ID);
  localparam logic [4:0] DIR_E = 5'b00001;
  localparam logic [4:0] DIR_W = 5'b00010;
  localparam logic [4:0] DIR_N = 5'b00100;
  localparam logic [4:0] DIR_S = 5'b01000;
  localparam logic [4:0] DIR_L = 5'b10000;

  function automatic logic [4:0] route(input logic [5:0] a);
    logic [4:0] d;
    logic [2:0] r;
    logic [2:0] c;
    r = a[5:3];
    c = a[2:0];
    unique case (1'b1)
      c > COL:               d = DIR_E;
      c < COL:               d = DIR_W;
      c == COL && r > ROW:   d = DIR_N;
      c == COL && r < ROW:   d = DIR_S;
      default:               d = DIR_L;
    endcase
    return d;
  endfunction

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      out_valid_q, out_valid_d;
  logic [23:0]     out_addr_q, out_addr_d;
  logic [4*PW-1:0] out_data_q, out_data_d;
  logic [19:0]     out_dir_q, out_dir_d;
  logic            ej_valid_q, ej_valid_d;
  logic [5:0]      ej_addr_q, ej_addr_d;
  logic [PW-1:0]   ej_data_q, ej_data_d;

  logic [3:0]      ej_sel, inj_sel, free;
  logic            link_ej, self_ej, deq, enq, nonempty;
  logic [5:0]      head_addr;
  logic [PW-1:0]   head_data;
  logic [4:0]      head_dir;
  logic [4:0]      dir_i;

`ifdef INJ_STATS_EN
  logic [15:0] stat_inj_q, stat_inj_d;
  logic [15:0] stat_ej_q, stat_ej_d;
  logic [15:0] stat_stall_q, stat_stall_d;
`endif

  assign loc_ready = (cnt_q != CW'(DEPTH));

  always_comb begin
    link_ej   = 1'b0;
    ej_sel    = '0;
    inj_sel   = '0;
    self_ej   = 1'b0;
    deq       = 1'b0;
    dir_i     = '0;
    head_addr = mem_q[rd_ptr_q][EW-1:PW];
    head_data = mem_q[rd_ptr_q][PW-1:0];
    head_dir  = route(head_addr);
    nonempty  = (cnt_q != '0);
    enq       = loc_valid && loc_ready;

    for (int i = 0; i < 4; i++) begin
      if (!link_ej && in_valid[i] && route(in_addr[6*i +: 6]) == DIR_L) begin
        link_ej   = 1'b1;
        ej_sel[i] = 1'b1;
      end
    end
    free = ~in_valid | ej_sel;

    // A self-addressed head only uses the ejection port, never a slot.
    if (nonempty) begin
      if (head_dir == DIR_L) begin
        if (!link_ej) begin
          self_ej = 1'b1;
          deq     = 1'b1;
        end
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (free[i] && !deq) begin
            inj_sel[i] = 1'b1;
            deq        = 1'b1;
          end
        end
      end
    end

    out_valid_d = '0;
    out_addr_d  = '0;
    out_data_d  = '0;
    out_dir_d   = '0;
    for (int i = 0; i < 4; i++) begin
      dir_i = route(in_addr[6*i +: 6]);
      if (inj_sel[i]) begin
        out_valid_d[i]        = 1'b1;
        out_addr_d[6*i +: 6]  = head_addr;
        out_data_d[PW*i +: PW] = head_data;
        out_dir_d[5*i +: 5]   = head_dir;
      end else if (in_valid[i] && !ej_sel[i]) begin
        out_valid_d[i]        = 1'b1;
        out_addr_d[6*i +: 6]  = in_addr[6*i +: 6];
        out_data_d[PW*i +: PW] = in_data[PW*i +: PW];
        out_dir_d[5*i +: 5]   = dir_i;
      end
    end

    ej_valid_d = link_ej || self_ej;
    ej_addr_d  = '0;
    ej_data_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (ej_sel[i]) begin
        ej_addr_d = in_addr[6*i +: 6];
        ej_data_d = in_data[PW*i +: PW];
      end
    end
    if (self_ej) begin
      ej_addr_d = head_addr;
      ej_data_d = head_data;
    end

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = {loc_addr, loc_data};
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    cnt_d    = cnt_q + CW'(enq) - CW'(deq);

`ifdef INJ_STATS_EN
    stat_inj_d   = stat_inj_q;
    stat_ej_d    = stat_ej_q;
    stat_stall_d = stat_stall_q;
    if ((inj_sel != '0) && stat_inj_q != 16'hFFFF)
      stat_inj_d = stat_inj_q + 16'd1;
    if (ej_valid_d && stat_ej_q != 16'hFFFF)
      stat_ej_d = stat_ej_q + 16'd1;
    if (nonempty && !deq && stat_stall_q != 16'hFFFF)
      stat_stall_d = stat_stall_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_dir_q   <= '0;
      ej_valid_q  <= 1'b0;
      ej_addr_q   <= '0;
      ej_data_q   <= '0;
`ifdef INJ_STATS_EN
      stat_inj_q   <= '0;
      stat_ej_q    <= '0;
      stat_stall_q <= '0;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_dir_q   <= out_dir_d;
      ej_valid_q  <= ej_valid_d;
      ej_addr_q   <= ej_addr_d;
      ej_data_q   <= ej_data_d;
`ifdef INJ_STATS_EN
      stat_inj_q   <= stat_inj_d;
      stat_ej_q    <= stat_ej_d;
      stat_stall_q <= stat_stall_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_dir   = out_dir_q;
  assign ej_valid  = ej_valid_q;
  assign ej_addr   = ej_addr_q;
  assign ej_data   = ej_data_q;
`ifdef INJ_STATS_EN
  assign stat_inj   = stat_inj_q;
  assign stat_ej    = stat_ej_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_injection_scheduler.sv
// Directed vector bench for injection_scheduler (ROW_ID=4, COL_ID=4, DEPTH=4).
// Cycle table plus FIFO-wrap and mid-traffic reset sequences.
module tb_injection_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [23:0] in_addr;
  logic [31:0] in_data;
  logic        loc_valid;
  logic [5:0]  loc_addr;
  logic [7:0]  loc_data;
  logic        loc_ready;
  logic [3:0]  out_valid;
  logic [23:0] out_addr;
  logic [31:0] out_data;
  logic [19:0] out_dir;
  logic        ej_valid;
  logic [5:0]  ej_addr;
  logic [7:0]  ej_data;
`ifdef INJ_STATS_EN
  logic [15:0] stat_inj, stat_ej, stat_stall;
`endif

  injection_scheduler #(
    .ROW_ID(4), .COL_ID(4), .DEPTH(4), .PW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .loc_valid(loc_valid), .loc_addr(loc_addr), .loc_data(loc_data),
    .loc_ready(loc_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .out_dir(out_dir),
    .ej_valid(ej_valid), .ej_addr(ej_addr), .ej_data(ej_data)
`ifdef INJ_STATS_EN
    ,
    .stat_inj(stat_inj), .stat_ej(stat_ej), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [4:0] E = 5'b00001;
  localparam logic [4:0] W = 5'b00010;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] L = 5'b10000;

  typedef struct {
    logic [3:0]  iv;
    logic [23:0] ia;
    logic [31:0] id;
    logic        lv;
    logic [5:0]  la;
    logic [7:0]  ld;
    logic [3:0]  ov;
    logic [23:0] oa;
    logic [31:0] od;
    logic [19:0] odir;
    logic        ev;
    logic [5:0]  ea;
    logic [7:0]  ed;
    logic        rdy;
  } vec_t;

  vec_t tv[19];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string p, input vec_t v);
    chk({p, " out_valid"}, 64'(out_valid), 64'(v.ov));
    chk({p, " out_addr"}, 64'(out_addr), 64'(v.oa));
    chk({p, " out_data"}, 64'(out_data), 64'(v.od));
    chk({p, " out_dir"}, 64'(out_dir), 64'(v.odir));
    chk({p, " ej_valid"}, 64'(ej_valid), 64'(v.ev));
    chk({p, " ej_addr"}, 64'(ej_addr), 64'(v.ea));
    chk({p, " ej_data"}, 64'(ej_data), 64'(v.ed));
    chk({p, " loc_ready"}, 64'(loc_ready), 64'(v.rdy));
  endtask

  initial begin
    logic [23:0] ia_a, ia_l, ia_b;
    logic [31:0] da, db;
    logic [5:0]  wa;
    vec_t        z;

    ia_a = {6'h3F, 6'h24, 6'h14, 6'h26};
    ia_l = {6'h24, 6'h00, 6'h00, 6'h24};
    ia_b = {6'h3F, 6'h14, 6'h26, 6'h00};
    da   = 32'hA3A2A1A0;
    db   = 32'hB3B2B1B0;
    z    = '{4'h0, 24'h0, 32'h0, 1'b0, 6'h0, 8'h0,
             4'h0, 24'h0, 32'h0, 20'h0, 1'b0, 6'h0, 8'h0, 1'b1};

    // idle, then routing E / S of injected heads
    tv[0]  = z;
    tv[1]  = z; tv[1].lv = 1; tv[1].la = 6'h26; tv[1].ld = 8'h11;
    tv[2]  = '{4'h0, 24'h0, 32'h0, 1'b1, 6'h14, 8'h22,
               4'h1, 24'h26, 32'h11, {15'h0, E}, 1'b0, 6'h0, 8'h0, 1'b1};
    tv[3]  = '{4'h0, 24'h0, 32'h0, 1'b0, 6'h00, 8'h00,
               4'h1, 24'h14, 32'h22, {15'h0, S}, 1'b0, 6'h0, 8'h0, 1'b1};
    // ejection frees slot 2 for the head
    tv[4]  = z; tv[4].lv = 1; tv[4].la = 6'h00; tv[4].ld = 8'h33;
    tv[5]  = '{4'hF, ia_a, da, 1'b0, 6'h0, 8'h0,
               4'hF, {6'h3F, 6'h00, 6'h14, 6'h26}, 32'hA333A1A0,
               {E, W, S, E}, 1'b1, 6'h24, 8'hA2, 1'b1};
    // double local with self-addressed head waiting
    tv[6]  = z; tv[6].lv = 1; tv[6].la = 6'h24; tv[6].ld = 8'h44;
    tv[7]  = '{4'h9, ia_l, da, 1'b0, 6'h0, 8'h0,
               4'h8, {6'h24, 18'h0}, 32'hA3000000, {L, 15'h0},
               1'b1, 6'h24, 8'hA0, 1'b1};
    tv[8]  = z; tv[8].ev = 1; tv[8].ea = 6'h24; tv[8].ed = 8'h44;
    // all slots busy: stall and backpressure
    for (int k = 9; k <= 13; k++) begin
      tv[k] = '{4'hF, ia_b, db, 1'b1, 6'(k - 8), 8'(8'h50 + k - 8),
                4'hF, ia_b, db, {E, S, E, W}, 1'b0, 6'h0, 8'h0,
                (k < 12)};
    end
    tv[14] = '{4'h0, 24'h0, 32'h0, 1'b0, 6'h0, 8'h0,
               4'h1, 24'h01, 32'h51, {15'h0, W}, 1'b0, 6'h0, 8'h0, 1'b1};
    tv[15] = '{4'h1, ia_b, db, 1'b0, 6'h0, 8'h0,
               4'h3, {12'h0, 6'h02, 6'h00}, 32'h000052B0,
               {10'h0, W, W}, 1'b0, 6'h0, 8'h0, 1'b1};
    tv[16] = '{4'h7, ia_b, db, 1'b0, 6'h0, 8'h0,
               4'hF, {6'h03, 6'h14, 6'h26, 6'h00}, 32'h53B2B1B0,
               {W, S, E, W}, 1'b0, 6'h0, 8'h0, 1'b1};
    tv[17] = '{4'h0, 24'h0, 32'h0, 1'b0, 6'h0, 8'h0,
               4'h1, 24'h04, 32'h54, {15'h0, S}, 1'b0, 6'h0, 8'h0, 1'b1};
    tv[18] = z;

    rst_n = 1'b0;
    in_valid = '0; in_addr = '0; in_data = '0;
    loc_valid = 1'b0; loc_addr = '0; loc_data = '0;
    #1;
    check_all("reset", z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      in_valid  = tv[k].iv;
      in_addr   = tv[k].ia;
      in_data   = tv[k].id;
      loc_valid = tv[k].lv;
      loc_addr  = tv[k].la;
      loc_data  = tv[k].ld;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", k), tv[k]);
    end

    // FIFO wrap: one flit in flight, enqueue and dequeue every cycle
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      in_valid  = '0;
      loc_valid = (k < 13);
      loc_addr  = {3'(k), 3'b000};
      loc_data  = 8'(8'h60 + k);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d ready", k), 64'(loc_ready), 64'd1);
      if (k == 0) begin
        chk("wrap0 out_valid", 64'(out_valid), 64'd0);
      end else begin
        wa = {3'(k - 1), 3'b000};
        chk($sformatf("wrap%0d out_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("wrap%0d addr", k), 64'(out_addr), 64'(wa));
        chk($sformatf("wrap%0d data", k), 64'(out_data),
            64'(8'h60 + k - 1));
        chk($sformatf("wrap%0d dir", k), 64'(out_dir), 64'(W));
      end
    end
    @(negedge clk);
    loc_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap drained", 64'(out_valid), 64'd0);

    // queue 3 flits behind busy links, then reset mid-traffic
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid  = 4'hF;
      in_addr   = ia_b;
      in_data   = db;
      loc_valid = 1'b1;
      loc_addr  = 6'(6'h30 + k);
      loc_data  = 8'(8'h70 + k);
      @(posedge clk);
      #1;
    end
`ifdef INJ_STATS_EN
    chk("stat_inj", 64'(stat_inj), 64'd20);
    chk("stat_ej", 64'(stat_ej), 64'd3);
    chk("stat_stall", 64'(stat_stall), 64'd7);
`endif
    @(negedge clk);
    loc_valid = 1'b0;
    chk("pre-reset out_valid", 64'(out_valid), 64'hF);
    chk("pre-reset ready", 64'(loc_ready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midreset", z);
`ifdef INJ_STATS_EN
    chk("rst stat_inj", 64'(stat_inj), 64'd0);
    chk("rst stat_stall", 64'(stat_stall), 64'd0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = '0;
    in_addr  = '0;
    in_data  = '0;
    @(posedge clk);
    #1;
    check_all("post-reset", z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
